// File: rtl/rhd_spi_pkg.sv
// Shared definitions for the C-port SPI frame sequencer.
//   state_t    : word engine states
//   RX1_LSB / RX2_LSB / WORD_BITS : placement of the two MISO words in a FIFO entry
//   SAT16_MAX / sat_inc16 : saturating 16-bit event counters
package rhd_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_GAP
    } state_t;

    localparam int WORD_BITS = 16;
    localparam int RX1_LSB   = 0;
    localparam int RX2_LSB   = 16;

    localparam logic [15:0] SAT16_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == SAT16_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rhd_spi_word.sv
// One 16-bit SPI word with simultaneous capture from two MISO lines.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start, cmd           : begin a word with this command (accepted in IDLE or on the last GAP cycle)
//   miso1, miso2         : serial data from the two chips
//   spi_cs/sclk/mosi     : registered SPI outputs
//   rx1_word, rx2_word   : received words, valid while word_done is high
//   word_done            : high on the cycle of the final sample (the edge that enters GAP)
//   gap_done             : high on the last GAP cycle
//
// state    | meaning
// IDLE     | CS high, waiting for start
// SETUP    | CS low, SCLK low, MOSI = cmd[15], CS_SETUP cycles
// SHIFT_LO | SCLK low SCLK_HALF cycles, MOSI = cmd[bit]
// SHIFT_HI | SCLK high SCLK_HALF cycles, sample MISO on the last one
// GAP      | CS high CS_GAP cycles; may chain straight into SETUP
module rhd_spi_word
    import rhd_spi_pkg::*;
#(
    parameter int SCLK_HALF = 4,
    parameter int CS_SETUP  = 2,
    parameter int CS_GAP    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] cmd,
    input  logic        miso1,
    input  logic        miso2,
    output logic        spi_cs,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic [15:0] rx1_word,
    output logic [15:0] rx2_word,
    output logic        word_done,
    output logic        gap_done
);

    localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
    localparam logic [7:0] HALF_LD  = 8'(SCLK_HALF - 1);
    localparam logic [7:0] GAP_LD   = 8'(CS_GAP - 1);

    state_t      state;
    logic [7:0]  timer;
    logic [3:0]  bit_idx;
    logic [15:0] cmd_q;
    logic [14:0] rx1;
    logic [14:0] rx2;
    logic        tc;

    assign tc        = (timer == 8'd0);
    assign word_done = (state == ST_SHIFT_HI) && tc && (bit_idx == 4'd0);
    assign gap_done  = (state == ST_GAP) && tc;
    // Final bit is taken straight from the pins so the word is complete on word_done.
    assign rx1_word  = {rx1, miso1};
    assign rx2_word  = {rx2, miso2};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            timer    <= 8'd0;
            bit_idx  <= 4'd0;
            cmd_q    <= 16'd0;
            rx1      <= 15'd0;
            rx2      <= 15'd0;
            spi_cs   <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SETUP;
                        cmd_q    <= cmd;
                        timer    <= SETUP_LD;
                        spi_cs   <= 1'b0;
                        spi_sclk <= 1'b0;
                        spi_mosi <= cmd[15];
                    end
                end
                ST_SETUP: begin
                    if (tc) begin
                        state    <= ST_SHIFT_LO;
                        timer    <= HALF_LD;
                        bit_idx  <= 4'd15;
                        spi_mosi <= cmd_q[15];
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tc) begin
                        state    <= ST_SHIFT_HI;
                        timer    <= HALF_LD;
                        spi_sclk <= 1'b1;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tc) begin
                        rx1      <= {rx1[13:0], miso1};
                        rx2      <= {rx2[13:0], miso2};
                        spi_sclk <= 1'b0;
                        if (bit_idx == 4'd0) begin
                            state  <= ST_GAP;
                            timer  <= GAP_LD;
                            spi_cs <= 1'b1;
                        end else begin
                            state    <= ST_SHIFT_LO;
                            timer    <= HALF_LD;
                            bit_idx  <= bit_idx - 4'd1;
                            spi_mosi <= cmd_q[bit_idx - 4'd1];
                        end
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (tc) begin
                        if (start) begin
                            state    <= ST_SETUP;
                            cmd_q    <= cmd;
                            timer    <= SETUP_LD;
                            spi_cs   <= 1'b0;
                            spi_mosi <= cmd[15];
                        end else begin
                            state    <= ST_IDLE;
                            spi_mosi <= 1'b0;
                        end
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rhd_spi_sequencer.sv
// Frame-level SPI sequencer: plays the command table out one word per CS cycle,
// pushes a frame header and one {rx2,rx1} entry per word into the read FIFO.
// Ports:
//   bus_clk, reset               : clock, synchronous active-high reset
//   enable, frame_trig           : frame start control
//   cmd_wr, cmd_addr, cmd_data   : command table write port
//   spi_cs/sclk/mosi, spi_miso1/2: SPI pins
//   fifo_din, fifo_wr_en, fifo_full : read FIFO push side
//   busy, frame_count, drop_count, trig_miss_count : status
module rhd_spi_sequencer
    import rhd_spi_pkg::*;
#(
    parameter int N_CMDS    = 35,
    parameter int SCLK_HALF = 4,
    parameter int CS_SETUP  = 2,
    parameter int CS_GAP    = 4
) (
    input  logic        bus_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_trig,
    input  logic        cmd_wr,
    input  logic [5:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        spi_cs,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso1,
    input  logic        spi_miso2,
    output logic [31:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic        busy,
    output logic [31:0] frame_count,
    output logic [15:0] drop_count,
    output logic [15:0] trig_miss_count
);

    localparam logic [5:0] LAST_IDX  = 6'(N_CMDS - 1);
    localparam logic [6:0] TBL_DEPTH = 7'(N_CMDS);

    logic [15:0] cmd_tbl [N_CMDS];
    logic [5:0]  idx;
    logic [5:0]  idx_next;
    logic        launch;
    logic        accept;
    logic        last_word;
    logic        eng_start;
    logic [15:0] eng_cmd;
    logic        word_done;
    logic        gap_done;
    logic [15:0] rx1_word;
    logic [15:0] rx2_word;
    logic        push_req;
    logic [31:0] push_data;

    // Table is deliberately not reset so the host programs it once.
    always_ff @(posedge bus_clk) begin
        if (cmd_wr && ({1'b0, cmd_addr} < TBL_DEPTH))
            cmd_tbl[cmd_addr] <= cmd_data;
    end

    assign idx_next  = idx + 6'd1;
    assign last_word = (idx == LAST_IDX);
    assign accept    = frame_trig && enable && !busy;
    // launch delays the first word by one cycle so CS falls one edge after the trigger.
    assign eng_start = launch || (gap_done && !last_word);
    assign eng_cmd   = launch ? cmd_tbl[0] : cmd_tbl[idx_next];
    assign push_req  = accept || word_done;

    always_comb begin
        push_data = frame_count;
        if (!accept) begin
            push_data = 32'd0;
            push_data[RX1_LSB +: WORD_BITS] = rx1_word;
            push_data[RX2_LSB +: WORD_BITS] = rx2_word;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            busy            <= 1'b0;
            launch          <= 1'b0;
            idx             <= 6'd0;
            frame_count     <= 32'd0;
            drop_count      <= 16'd0;
            trig_miss_count <= 16'd0;
            fifo_wr_en      <= 1'b0;
            fifo_din        <= 32'd0;
        end else begin
            launch     <= accept;
            fifo_wr_en <= 1'b0;
            if (frame_trig) begin
                if (accept) begin
                    busy        <= 1'b1;
                    idx         <= 6'd0;
                    frame_count <= frame_count + 32'd1;
                end else begin
                    trig_miss_count <= sat_inc16(trig_miss_count);
                end
            end
            if (gap_done) begin
                if (last_word)
                    busy <= 1'b0;
                else
                    idx <= idx_next;
            end
            if (push_req) begin
                if (fifo_full) begin
                    drop_count <= sat_inc16(drop_count);
                end else begin
                    fifo_wr_en <= 1'b1;
                    fifo_din   <= push_data;
                end
            end
        end
    end

    rhd_spi_word #(
        .SCLK_HALF (SCLK_HALF),
        .CS_SETUP  (CS_SETUP),
        .CS_GAP    (CS_GAP)
    ) u_word (
        .clk       (bus_clk),
        .reset     (reset),
        .start     (eng_start),
        .cmd       (eng_cmd),
        .miso1     (spi_miso1),
        .miso2     (spi_miso2),
        .spi_cs    (spi_cs),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .rx1_word  (rx1_word),
        .rx2_word  (rx2_word),
        .word_done (word_done),
        .gap_done  (gap_done)
    );

endmodule
